// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared definitions for the multicycle controller and the
//               datapath: decoded instruction classes, controller states and
//               the encodings of the PC, writeback and access-size selects.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Pre-decoded instruction class delivered by the instruction decoder.
    typedef enum logic [3:0] {
        CLS_ALU_R   = 4'd0,
        CLS_ALU_I   = 4'd1,
        CLS_SLT_R   = 4'd2,
        CLS_SLT_I   = 4'd3,
        CLS_MUL_LO  = 4'd4,
        CLS_MUL_HI  = 4'd5,
        CLS_LOAD    = 4'd6,
        CLS_STORE   = 4'd7,
        CLS_BEQ     = 4'd8,
        CLS_BNE     = 4'd9,
        CLS_J       = 4'd10,
        CLS_JAL     = 4'd11,
        CLS_JR      = 4'd12,
        CLS_MFSR    = 4'd13,
        CLS_HALT    = 4'd14,
        CLS_ILLEGAL = 4'd15
    } instr_class_e;

    // Controller states; the encoding is visible on the debug port.
    typedef enum logic [3:0] {
        ST_RST       = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_EXEC      = 4'd3,
        ST_MUL_WAIT  = 4'd4,
        ST_MEM_RD    = 4'd5,
        ST_MEM_LATCH = 4'd6,
        ST_MEM_WR    = 4'd7,
        ST_WB        = 4'd8,
        ST_HALT      = 4'd9,
        ST_FAULT     = 4'd10
    } state_e;

    // Next-PC source select.
    localparam logic [1:0] c_PC_SEL_PLUS4  = 2'd0;
    localparam logic [1:0] c_PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] c_PC_SEL_JR     = 2'd2;
    localparam logic [1:0] c_PC_SEL_JUMP   = 2'd3;

    // Register-file write address select.
    localparam logic [1:0] c_WADDR_RD = 2'd0;
    localparam logic [1:0] c_WADDR_RT = 2'd1;
    localparam logic [1:0] c_WADDR_RA = 2'd2;

    // Register-file write data select.
    localparam logic [1:0] c_WDATA_ALU = 2'd0;
    localparam logic [1:0] c_WDATA_MDR = 2'd1;
    localparam logic [1:0] c_WDATA_PC4 = 2'd2;
    localparam logic [1:0] c_WDATA_SR  = 2'd3;

    // Data-memory access size.
    localparam logic [1:0] c_MEM_BYTE = 2'd0;
    localparam logic [1:0] c_MEM_HALF = 2'd1;
    localparam logic [1:0] c_MEM_WORD = 2'd2;

    // Anything narrower than a full word must be merged into the existing
    // memory word, so it takes the read-modify-write path.
    function automatic logic f_is_subword(input logic [1:0] size);
        return (size != c_MEM_WORD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/multi_ctrl_fsm_mul_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : mul_watchdog
// Description : Cycle counter for the multiplier wait state. Cleared when the
//               controller enters the wait state, counts 0,1,2,... while
//               enabled and flags the last permitted cycle.
// Ports       : clk, rst   - clock, asynchronous active-high reset
//               i_clr      - clear the count (wait-state entry)
//               i_en       - controller is in the wait state
//               o_timeout  - current cycle is index MUL_TIMEOUT-1
// Revision    : 1.0 - initial release
// ============================================================================
module mul_watchdog #(
    parameter int MUL_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam int              c_CW   = (MUL_TIMEOUT > 1) ? $clog2(MUL_TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(MUL_TIMEOUT - 1);

    logic [c_CW-1:0] r_cnt;

    // Count holds at the last index so it can never wrap back to a
    // non-timeout value if the controller lingered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != c_LAST)) begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    assign o_timeout = i_en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/multi_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : multi_ctrl_fsm
// Description : Main sequencing FSM of the multicycle datapath
//               (fetch/decode/execute/memory/writeback) with run/step gating,
//               halt and fault handling, a multiplier watchdog and a
//               retired-instruction counter.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               run, step       - free-run level / single-fetch pulse
//               instr_class     - decoded class, stable while IR is stable
//               mem_size        - decoded access size
//               mul_valid_out   - multiplier result ready
//               clr_pc..flag_en - datapath strobes and mux selects
//               clr_flag        - status flag clear
//               halted, fault   - sticky status
//               state_dbg       - current state encoding
//               retired_cnt     - instructions retired (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module multi_ctrl_fsm #(
    parameter int MUL_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic [3:0]       instr_class,
    input  logic [1:0]       mem_size,
    input  logic             mul_valid_out,
    output logic             clr_pc,
    output logic             ld_pc,
    output logic [1:0]       pc_sel,
    output logic             clr_ir,
    output logic             ld_ir,
    output logic             ld_a,
    output logic             ld_b,
    output logic             ld_aluout,
    output logic             ld_mdr,
    output logic             alu_b_sel,
    output logic             use_slt,
    output logic             use_mul,
    output logic             mul_valid_in,
    output logic             mem_en_ctrl,
    output logic             mem_wen_ctrl,
    output logic             reg_we,
    output logic [1:0]       waddr_sel,
    output logic [1:0]       wdata_sel,
    output logic             flag_en,
    output logic [3:0]       clr_flag,
    output logic             halted,
    output logic             fault,
    output logic [3:0]       state_dbg,
    output logic [CNT_W-1:0] retired_cnt
);

    import ctrl_pkg::*;

    state_e           r_state;
    state_e           w_next;
    instr_class_e     w_cls;
    logic             w_mul_timeout;
    logic             w_mul_enter;
    logic [CNT_W-1:0] r_retired;

    assign w_cls = instr_class_e'(instr_class);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RST:    w_next = ST_FETCH;
            ST_FETCH:  if (run || step) w_next = ST_DECODE;
            ST_DECODE: w_next = (w_cls == CLS_ILLEGAL) ? ST_FAULT : ST_EXEC;
            ST_EXEC: begin
                case (w_cls)
                    CLS_ALU_R, CLS_ALU_I,
                    CLS_SLT_R, CLS_SLT_I:   w_next = ST_WB;
                    CLS_MUL_LO, CLS_MUL_HI: w_next = ST_MUL_WAIT;
                    CLS_LOAD:               w_next = ST_MEM_RD;
                    CLS_STORE:              w_next = f_is_subword(mem_size) ? ST_MEM_RD : ST_MEM_WR;
                    CLS_BEQ, CLS_BNE, CLS_J,
                    CLS_JAL, CLS_JR, CLS_MFSR: w_next = ST_FETCH;
                    CLS_HALT:               w_next = ST_HALT;
                    default:                w_next = ST_FAULT;
                endcase
            end
            // A result on the final permitted cycle still completes.
            ST_MUL_WAIT: begin
                if (mul_valid_out) begin
                    w_next = ST_WB;
                end else if (w_mul_timeout) begin
                    w_next = ST_FAULT;
                end
            end
            ST_MEM_RD:    w_next = ST_MEM_LATCH;
            // Sub-word stores come through here to capture the merge word.
            ST_MEM_LATCH: w_next = (w_cls == CLS_STORE) ? ST_MEM_WR : ST_WB;
            ST_MEM_WR:    w_next = ST_FETCH;
            ST_WB:        w_next = ST_FETCH;
            ST_HALT:      w_next = ST_HALT;
            ST_FAULT:     w_next = ST_FAULT;
            default:      w_next = ST_FAULT;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        clr_pc       = 1'b0;
        ld_pc        = 1'b0;
        pc_sel       = c_PC_SEL_PLUS4;
        clr_ir       = 1'b0;
        ld_ir        = 1'b0;
        ld_a         = 1'b0;
        ld_b         = 1'b0;
        ld_aluout    = 1'b0;
        ld_mdr       = 1'b0;
        alu_b_sel    = 1'b0;
        use_slt      = 1'b0;
        use_mul      = 1'b0;
        mul_valid_in = 1'b0;
        mem_en_ctrl  = 1'b0;
        mem_wen_ctrl = 1'b0;
        reg_we       = 1'b0;
        waddr_sel    = c_WADDR_RD;
        wdata_sel    = c_WDATA_ALU;
        flag_en      = 1'b0;
        clr_flag     = 4'h0;
        halted       = 1'b0;
        fault        = 1'b0;
        case (r_state)
            ST_RST: begin
                clr_pc   = 1'b1;
                clr_ir   = 1'b1;
                clr_flag = 4'hF;
            end
            ST_FETCH: begin
                ld_ir = run || step;
            end
            ST_DECODE: begin
                ld_a = 1'b1;
                ld_b = 1'b1;
            end
            ST_EXEC: begin
                case (w_cls)
                    CLS_ALU_R, CLS_ALU_I, CLS_SLT_R, CLS_SLT_I: begin
                        ld_aluout = 1'b1;
                        alu_b_sel = (w_cls == CLS_ALU_I) || (w_cls == CLS_SLT_I);
                        use_slt   = (w_cls == CLS_SLT_R) || (w_cls == CLS_SLT_I);
                    end
                    CLS_MUL_LO, CLS_MUL_HI: begin
                        // EXEC lasts one cycle, so this is a single pulse.
                        mul_valid_in = 1'b1;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_b_sel = 1'b1;
                        ld_aluout = 1'b1;
                    end
                    CLS_BEQ, CLS_BNE: begin
                        ld_pc  = 1'b1;
                        pc_sel = c_PC_SEL_BRANCH;
                    end
                    CLS_J: begin
                        ld_pc  = 1'b1;
                        pc_sel = c_PC_SEL_JUMP;
                    end
                    CLS_JAL: begin
                        // Link write uses PC+4 of the old PC in the same cycle.
                        ld_pc     = 1'b1;
                        pc_sel    = c_PC_SEL_JUMP;
                        reg_we    = 1'b1;
                        waddr_sel = c_WADDR_RA;
                        wdata_sel = c_WDATA_PC4;
                    end
                    CLS_JR: begin
                        ld_pc  = 1'b1;
                        pc_sel = c_PC_SEL_JR;
                    end
                    CLS_MFSR: begin
                        reg_we    = 1'b1;
                        waddr_sel = c_WADDR_RD;
                        wdata_sel = c_WDATA_SR;
                        ld_pc     = 1'b1;
                        pc_sel    = c_PC_SEL_PLUS4;
                    end
                    default: begin
                    end
                endcase
            end
            ST_MUL_WAIT: begin
                use_mul   = 1'b1;
                ld_aluout = mul_valid_out;
            end
            ST_MEM_RD: begin
                mem_en_ctrl = 1'b1;
            end
            ST_MEM_LATCH: begin
                ld_mdr = 1'b1;
            end
            ST_MEM_WR: begin
                mem_en_ctrl  = 1'b1;
                mem_wen_ctrl = 1'b1;
                ld_pc        = 1'b1;
                pc_sel       = c_PC_SEL_PLUS4;
            end
            ST_WB: begin
                reg_we = 1'b1;
                ld_pc  = 1'b1;
                pc_sel = c_PC_SEL_PLUS4;
                case (w_cls)
                    CLS_LOAD: begin
                        waddr_sel = c_WADDR_RT;
                        wdata_sel = c_WDATA_MDR;
                    end
                    CLS_ALU_I, CLS_SLT_I: begin
                        waddr_sel = c_WADDR_RT;
                        wdata_sel = c_WDATA_ALU;
                    end
                    default: begin
                        waddr_sel = c_WADDR_RD;
                        wdata_sel = c_WDATA_ALU;
                    end
                endcase
                flag_en = (w_cls == CLS_ALU_R) || (w_cls == CLS_ALU_I) ||
                          (w_cls == CLS_SLT_R) || (w_cls == CLS_SLT_I);
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            ST_FAULT: begin
                fault  = 1'b1;
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Multiplier watchdog: cleared on the EXEC -> MUL_WAIT transition so
    // the first wait cycle sees count 0.
    // ------------------------------------------------------------------
    assign w_mul_enter = (r_state != ST_MUL_WAIT) && (w_next == ST_MUL_WAIT);

    mul_watchdog #(
        .MUL_TIMEOUT (MUL_TIMEOUT)
    ) u_mul_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_mul_enter),
        .i_en      (r_state == ST_MUL_WAIT),
        .o_timeout (w_mul_timeout)
    );

    // ------------------------------------------------------------------
    // Retired-instruction counter: every instruction retires on exactly
    // the edge that loads the PC.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= '0;
        end else if (ld_pc) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign retired_cnt = r_retired;
    assign state_dbg   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multi_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_ctrl_fsm
// Description : Directed self-checking bench for multi_ctrl_fsm. Strobes are
//               packed into one vector and compared against hand-computed
//               constants per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_ctrl_fsm;

    import ctrl_pkg::*;

    // Strobe vector bit masks (see the concatenation below).
    localparam logic [15:0] c_CLR_PC  = 16'h8000;
    localparam logic [15:0] c_LD_PC   = 16'h4000;
    localparam logic [15:0] c_CLR_IR  = 16'h2000;
    localparam logic [15:0] c_LD_IR   = 16'h1000;
    localparam logic [15:0] c_LD_A    = 16'h0800;
    localparam logic [15:0] c_LD_B    = 16'h0400;
    localparam logic [15:0] c_LD_ALU  = 16'h0200;
    localparam logic [15:0] c_LD_MDR  = 16'h0100;
    localparam logic [15:0] c_B_SEL   = 16'h0080;
    localparam logic [15:0] c_USE_SLT = 16'h0040;
    localparam logic [15:0] c_USE_MUL = 16'h0020;
    localparam logic [15:0] c_MUL_IN  = 16'h0010;
    localparam logic [15:0] c_MEM_EN  = 16'h0008;
    localparam logic [15:0] c_MEM_WEN = 16'h0004;
    localparam logic [15:0] c_REG_WE  = 16'h0002;
    localparam logic [15:0] c_FLAG_EN = 16'h0001;

    logic        clk;
    logic        rst;
    logic        run;
    logic        step;
    logic [3:0]  instr_class;
    logic [1:0]  mem_size;
    logic        mul_valid_out;
    logic        clr_pc, ld_pc, clr_ir, ld_ir, ld_a, ld_b, ld_aluout, ld_mdr;
    logic        alu_b_sel, use_slt, use_mul, mul_valid_in;
    logic        mem_en_ctrl, mem_wen_ctrl, reg_we, flag_en;
    logic [1:0]  pc_sel, waddr_sel, wdata_sel;
    logic [3:0]  clr_flag;
    logic        halted, fault;
    logic [3:0]  state_dbg;
    logic [15:0] retired_cnt;
    logic [15:0] strb;
    logic [5:0]  sels;

    int n_checks = 0;
    int n_fail   = 0;

    multi_ctrl_fsm #(
        .MUL_TIMEOUT (16),
        .CNT_W       (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .step          (step),
        .instr_class   (instr_class),
        .mem_size      (mem_size),
        .mul_valid_out (mul_valid_out),
        .clr_pc        (clr_pc),
        .ld_pc         (ld_pc),
        .pc_sel        (pc_sel),
        .clr_ir        (clr_ir),
        .ld_ir         (ld_ir),
        .ld_a          (ld_a),
        .ld_b          (ld_b),
        .ld_aluout     (ld_aluout),
        .ld_mdr        (ld_mdr),
        .alu_b_sel     (alu_b_sel),
        .use_slt       (use_slt),
        .use_mul       (use_mul),
        .mul_valid_in  (mul_valid_in),
        .mem_en_ctrl   (mem_en_ctrl),
        .mem_wen_ctrl  (mem_wen_ctrl),
        .reg_we        (reg_we),
        .waddr_sel     (waddr_sel),
        .wdata_sel     (wdata_sel),
        .flag_en       (flag_en),
        .clr_flag      (clr_flag),
        .halted        (halted),
        .fault         (fault),
        .state_dbg     (state_dbg),
        .retired_cnt   (retired_cnt)
    );

    assign strb = {clr_pc, ld_pc, clr_ir, ld_ir, ld_a, ld_b, ld_aluout, ld_mdr,
                   alu_b_sel, use_slt, use_mul, mul_valid_in,
                   mem_en_ctrl, mem_wen_ctrl, reg_we, flag_en};
    assign sels = {pc_sel, waddr_sel, wdata_sel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ck_st(input string tag, input int st, input logic [15:0] s);
        check({tag, "_state"}, 32'(state_dbg), 32'(st));
        check({tag, "_strb"}, 32'(strb), 32'(s));
    endtask

    // Advance one clock; inputs are changed and outputs sampled 2ns later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; step = 1'b0;
        instr_class = CLS_ALU_R; mem_size = c_MEM_WORD; mul_valid_out = 1'b0;
        repeat (2) tick();
        ck_st("rst", 0, c_CLR_PC | c_CLR_IR);
        check("rst_clr_flag", 32'(clr_flag), 32'hF);
        check("rst_halted", 32'(halted), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_cnt", 32'(retired_cnt), 0);

        // ALU_R, free running
        rst = 1'b0; run = 1'b1;
        tick(); ck_st("alu_f", 1, c_LD_IR);
        tick(); ck_st("alu_d", 2, c_LD_A | c_LD_B);
        tick(); ck_st("alu_e", 3, c_LD_ALU);
        tick(); ck_st("alu_wb", 8, c_LD_PC | c_REG_WE | c_FLAG_EN);
        check("alu_wb_sels", 32'(sels), 32'h00);
        tick(); ck_st("alu_ret", 1, c_LD_IR);
        check("alu_cnt", 32'(retired_cnt), 1);

        // LOAD byte
        instr_class = CLS_LOAD; mem_size = c_MEM_BYTE;
        tick(); ck_st("ld_d", 2, c_LD_A | c_LD_B);
        tick(); ck_st("ld_e", 3, c_B_SEL | c_LD_ALU);
        tick(); ck_st("ld_rd", 5, c_MEM_EN);
        tick(); ck_st("ld_lat", 6, c_LD_MDR);
        tick(); ck_st("ld_wb", 8, c_LD_PC | c_REG_WE);
        check("ld_wb_sels", 32'(sels), 32'b00_01_01);
        tick(); ck_st("ld_ret", 1, c_LD_IR);
        check("ld_cnt", 32'(retired_cnt), 2);

        // Sub-word STORE (half): read-modify-write path
        instr_class = CLS_STORE; mem_size = c_MEM_HALF;
        tick(); ck_st("sth_d", 2, c_LD_A | c_LD_B);
        tick(); ck_st("sth_e", 3, c_B_SEL | c_LD_ALU);
        tick(); ck_st("sth_rd", 5, c_MEM_EN);
        tick(); ck_st("sth_lat", 6, c_LD_MDR);
        tick(); ck_st("sth_wr", 7, c_MEM_EN | c_MEM_WEN | c_LD_PC);
        check("sth_pcsel", 32'(pc_sel), 0);
        tick(); ck_st("sth_ret", 1, c_LD_IR);
        check("sth_cnt", 32'(retired_cnt), 3);

        // Word STORE: straight to MEM_WR
        mem_size = c_MEM_WORD;
        tick(); ck_st("stw_d", 2, c_LD_A | c_LD_B);
        tick(); ck_st("stw_e", 3, c_B_SEL | c_LD_ALU);
        tick(); ck_st("stw_wr", 7, c_MEM_EN | c_MEM_WEN | c_LD_PC);
        tick(); ck_st("stw_ret", 1, c_LD_IR);
        check("stw_cnt", 32'(retired_cnt), 4);

        // MUL_LO, result on the 4th wait cycle
        instr_class = CLS_MUL_LO;
        tick(); ck_st("mul_d", 2, c_LD_A | c_LD_B);
        tick(); ck_st("mul_e", 3, c_MUL_IN);
        for (int i = 0; i < 3; i++) begin
            tick(); ck_st("mul_wait", 4, c_USE_MUL);
        end
        tick(); mul_valid_out = 1'b1; #1;
        ck_st("mul_valid", 4, c_USE_MUL | c_LD_ALU);
        tick(); mul_valid_out = 1'b0;
        ck_st("mul_wb", 8, c_LD_PC | c_REG_WE);
        check("mul_wb_sels", 32'(sels), 32'h00);
        tick(); ck_st("mul_ret", 1, c_LD_IR);
        check("mul_cnt", 32'(retired_cnt), 5);

        // MUL_HI, no result: watchdog fault after 16 wait cycles
        instr_class = CLS_MUL_HI;
        tick(); tick(); ck_st("mto_e", 3, c_MUL_IN);
        for (int i = 0; i < 16; i++) begin
            tick(); ck_st("mto_wait", 4, c_USE_MUL);
        end
        tick(); ck_st("mto_fault", 10, 16'h0000);
        check("mto_fault_flag", 32'(fault), 1);
        check("mto_halted", 32'(halted), 1);
        check("mto_cnt", 32'(retired_cnt), 5);
        run = 1'b0;
        repeat (3) tick();
        check("mto_stays", 32'(state_dbg), 10);

        // Asynchronous reset from FAULT, then single-step JAL / BNE
        rst = 1'b1; #1;
        check("arst_state", 32'(state_dbg), 0);
        check("arst_cnt", 32'(retired_cnt), 0);
        tick(); rst = 1'b0; instr_class = CLS_JAL;
        tick(); ck_st("st_park0", 1, 16'h0000);
        repeat (3) tick();
        ck_st("st_park1", 1, 16'h0000);
        step = 1'b1; #1;
        ck_st("jal_f", 1, c_LD_IR);
        tick(); step = 1'b0;
        ck_st("jal_d", 2, c_LD_A | c_LD_B);
        tick(); ck_st("jal_e", 3, c_LD_PC | c_REG_WE);
        check("jal_sels", 32'(sels), 32'b11_10_10);
        tick(); ck_st("jal_ret", 1, 16'h0000);
        check("jal_cnt", 32'(retired_cnt), 1);
        instr_class = CLS_BNE;
        repeat (10) tick();
        ck_st("st_park2", 1, 16'h0000);
        check("st_park_cnt", 32'(retired_cnt), 1);
        step = 1'b1; #1;
        ck_st("bne_f", 1, c_LD_IR);
        tick(); ck_st("bne_d", 2, c_LD_A | c_LD_B);
        // step still high in DECODE must not queue another fetch
        tick(); step = 1'b0;
        ck_st("bne_e", 3, c_LD_PC);
        check("bne_pcsel", 32'(pc_sel), 1);
        tick(); ck_st("bne_ret", 1, 16'h0000);
        repeat (2) tick();
        ck_st("bne_park", 1, 16'h0000);
        check("bne_cnt", 32'(retired_cnt), 2);

        // MUL with result on the final permitted wait cycle: no fault
        instr_class = CLS_MUL_LO; run = 1'b1;
        tick(); run = 1'b0;
        ck_st("mlast_d", 2, c_LD_A | c_LD_B);
        tick(); ck_st("mlast_e", 3, c_MUL_IN);
        for (int i = 0; i < 15; i++) begin
            tick(); ck_st("mlast_wait", 4, c_USE_MUL);
        end
        tick(); mul_valid_out = 1'b1; #1;
        ck_st("mlast_valid", 4, c_USE_MUL | c_LD_ALU);
        tick(); mul_valid_out = 1'b0;
        ck_st("mlast_wb", 8, c_LD_PC | c_REG_WE);
        tick(); ck_st("mlast_ret", 1, 16'h0000);
        check("mlast_cnt", 32'(retired_cnt), 3);

        // Illegal class faults from DECODE
        instr_class = CLS_ILLEGAL; step = 1'b1;
        tick(); step = 1'b0;
        ck_st("ill_d", 2, c_LD_A | c_LD_B);
        tick(); ck_st("ill_fault", 10, 16'h0000);
        check("ill_fault_flag", 32'(fault), 1);

        // Reset asserted in the middle of a LOAD (during MEM_RD)
        rst = 1'b1;
        tick(); rst = 1'b0; instr_class = CLS_LOAD; mem_size = c_MEM_BYTE; run = 1'b1;
        tick(); tick(); tick();
        tick(); ck_st("rmid_rd", 5, c_MEM_EN);
        rst = 1'b1; #1;
        ck_st("rmid_rst", 0, c_CLR_PC | c_CLR_IR);
        check("rmid_clr_flag", 32'(clr_flag), 32'hF);
        check("rmid_cnt", 32'(retired_cnt), 0);
        check("rmid_fault", 32'(fault), 0);
        tick(); rst = 1'b0; instr_class = CLS_HALT;
        tick(); ck_st("hlt_f", 1, c_LD_IR);
        tick(); ck_st("hlt_d", 2, c_LD_A | c_LD_B);
        tick(); ck_st("hlt_e", 3, 16'h0000);
        tick(); ck_st("hlt_s", 9, 16'h0000);
        check("hlt_halted", 32'(halted), 1);
        check("hlt_fault", 32'(fault), 0);
        repeat (4) tick();
        check("hlt_hold", 32'(state_dbg), 9);
        check("hlt_hold_halted", 32'(halted), 1);
        check("hlt_cnt", 32'(retired_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
